// File: rtl/mc68030_pds_slave.sv
// mc68030_pds_slave: 68030 PDS target that decodes the card window and turns each CPU cycle
// into one backend request, ending it with a one-clock STERM# or with BERR# on backend timeout.
module mc68030_pds_slave #(
    parameter logic [3:0] CARD_ID        = 4'h9,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        cpuclk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        d_oe,
    input  logic        rwn,
    input  logic        asn,
    input  logic        dsn,
    input  logic [1:0]  siz,
    input  logic [2:0]  fc,
    output logic        stermn,
    output logic        berrn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, TERM, WAIT_AS} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic       rd, err, hit, tmo;
    logic [2:0] off, len;
    logic [3:0] be;

    assign hit = !asn && a[31:28] == 4'hF && a[27:24] == CARD_ID && fc != 3'b111 && (rwn || !dsn);
    assign tmo = cnt == 8'(TIMEOUT_CYCLES - 1);
    assign off = {1'b0, a[1:0]};
    assign len = siz == 2'b00 ? 3'd4 : {1'b0, siz};
    // Lanes from the starting byte up to the end of the transfer, clipped at the longword boundary.
    assign be  = (4'hF >> off) & ~(4'hF >> (off + len));

    always_ff @(posedge cpuclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = hit ? REQ : IDLE;
            REQ:     state_nxt = asn ? IDLE : mem_ack ? TERM : tmo ? WAIT_AS : REQ;
            TERM:    state_nxt = WAIT_AS;
            WAIT_AS: state_nxt = asn ? IDLE : WAIT_AS;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = state == REQ;
        stermn  = state != TERM;
        berrn   = !(state == WAIT_AS && err);
        d_oe    = rd && !err && (state == TERM || state == WAIT_AS);
    end

    always_ff @(posedge cpuclk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rd        <= 1'b0;
            err       <= 1'b0;
            d_out     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE && hit) begin
            cnt       <= '0;
            rd        <= rwn;
            err       <= 1'b0;
            mem_we    <= ~rwn;
            mem_addr  <= a[23:2];
            mem_be    <= be;
            mem_wdata <= d_in;
        end else if (state == REQ) begin
            cnt <= cnt + 8'd1;
            if (!asn && mem_ack && rd) d_out <= mem_rdata;
            if (!asn && !mem_ack && tmo) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mc68030_pds_slave.sv
// tb_mc68030_pds_slave: directed and random PDS cycles against a byte-lane memory reference model.
module tb_mc68030_pds_slave;
    localparam int TMO = 8;
    logic        cpuclk = 1'b0, reset = 1'b1;
    logic [31:0] a = '0, d_in = '0, d_out, mem_wdata, mem_rdata;
    logic        d_oe, rwn = 1'b1, asn = 1'b1, dsn = 1'b1, stermn, berrn, mem_req, mem_we, mem_ack;
    logic [1:0]  siz = '0;
    logic [2:0]  fc = 3'd5;
    logic [21:0] mem_addr;
    logic [3:0]  mem_be;
    int          checks = 0, errors = 0, lat = 0, req_cyc = 0;
    logic        never_ack = 1'b0;
    logic [31:0] bram [64];
    logic [7:0]  ref_mem [256];

    mc68030_pds_slave #(.CARD_ID(4'h9), .TIMEOUT_CYCLES(TMO)) dut (
        .cpuclk(cpuclk), .reset(reset), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .rwn(rwn), .asn(asn), .dsn(dsn), .siz(siz), .fc(fc), .stermn(stermn), .berrn(berrn),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    always #5 cpuclk = ~cpuclk;

    // Backend: acks after `lat` cycles of request (0 = same cycle), writes enabled lanes.
    assign mem_ack   = mem_req && !never_ack && req_cyc >= lat;
    assign mem_rdata = bram[mem_addr[5:0]];
    always @(posedge cpuclk) begin
        req_cyc <= mem_req ? req_cyc + 1 : 0;
        if (mem_req && mem_ack && mem_we)
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) bram[mem_addr[5:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {27'd0, stermn, berrn, d_oe, mem_req, mem_we}, 32'b11000);
        check({tag, "_addr"}, {10'd0, mem_addr}, 32'd0);
        check({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_dout"}, d_out, 32'd0);
    endtask

    task automatic bus_cycle(input logic [31:0] addr, input logic [31:0] data, input logic rd,
                             input logic [1:0] sz, input logic [2:0] fcode, input logic ds,
                             input int lat_i, input logic noack);
        logic       acc;
        logic [3:0] ebe;
        logic [31:0] eword;
        int n, base, hits;
        acc = addr[31:24] == 8'hF9 && fcode != 3'b111 && (rd || !ds);
        n = (sz == 2'b00) ? 4 : int'(sz);
        base = int'(addr[7:0]) & 'hFC;
        ebe = '0;
        for (int k = int'(addr[1:0]); k < 4 && k < int'(addr[1:0]) + n; k++) ebe[3-k] = 1'b1;
        eword = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
        lat = lat_i;
        never_ack = noack;
        @(negedge cpuclk);
        a = addr; d_in = data; rwn = rd; siz = sz; fc = fcode; asn = 1'b0; dsn = ds;
        if (!acc) begin
            repeat (10) begin
                @(negedge cpuclk);
                check("reject_quiet", {28'd0, mem_req, stermn, berrn, d_oe}, 32'b0110);
            end
        end else begin
            @(negedge cpuclk);
            check("req", {31'd0, mem_req}, 32'd1);
            check("we", {31'd0, mem_we}, {31'd0, ~rd});
            check("addr", {10'd0, mem_addr}, {10'd0, addr[23:2]});
            check("be", {28'd0, mem_be}, {28'd0, ebe});
            check("wdata", mem_wdata, data);
            a = $urandom; d_in = $urandom;
            hits = 1;
            while (stermn && berrn && hits < 40) begin
                @(negedge cpuclk);
                hits++;
            end
            if (noack) begin
                check("berr_time", hits, 1 + TMO);
                check("berr_low", {30'd0, berrn, stermn}, 32'b01);
                check("berr_req_drop", {31'd0, mem_req}, 32'd0);
                repeat (3) begin
                    @(negedge cpuclk);
                    check("berr_hold", {31'd0, berrn}, 32'd0);
                end
                asn = 1'b1;
                @(negedge cpuclk);
                check("berr_release", {30'd0, berrn, d_oe}, 32'b10);
            end else begin
                check("term_time", hits, 2 + lat_i);
                check("term_low", {29'd0, stermn, berrn, mem_req}, 32'b010);
                check("addr_held", {10'd0, mem_addr}, {10'd0, addr[23:2]});
                check("oe_term", {31'd0, d_oe}, {31'd0, rd});
                if (rd) check("rdata", d_out, eword);
                else
                    for (int k = int'(addr[1:0]); k < 4 && k < int'(addr[1:0]) + n; k++)
                        ref_mem[base+k] = data[31-8*k -: 8];
                @(negedge cpuclk);
                check("term_one_cycle", {31'd0, stermn}, 32'd1);
                check("oe_hold", {31'd0, d_oe}, {31'd0, rd});
                if (rd) check("rdata_hold", d_out, eword);
                asn = 1'b1;
                @(negedge cpuclk);
                check("oe_release", {30'd0, d_oe, stermn}, 32'b01);
            end
        end
        asn = 1'b1; dsn = 1'b1;
        @(negedge cpuclk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        for (int i = 0; i < 64; i++) bram[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        #1 check_reset_vals("reset");
        repeat (2) @(negedge cpuclk);
        reset = 1'b0;
        bus_cycle(32'hF9000000, 32'h87654321, 1'b0, 2'b00, 3'd5, 1'b0, 0, 1'b0);
        bus_cycle(32'hF9000000, 32'h0, 1'b1, 2'b00, 3'd5, 1'b0, 0, 1'b0);
        bus_cycle(32'hF9000013, 32'hAABBCCDD, 1'b0, 2'b01, 3'd1, 1'b0, 2, 1'b0);
        bus_cycle(32'hF9000001, 32'h11223344, 1'b0, 2'b10, 3'd1, 1'b0, 2, 1'b0);
        bus_cycle(32'hF9000010, 32'h0, 1'b1, 2'b11, 3'd2, 1'b0, 1, 1'b0);
        bus_cycle(32'hFA000000, 32'h1, 1'b0, 2'b00, 3'd5, 1'b0, 0, 1'b0);
        bus_cycle(32'hE9000000, 32'h2, 1'b1, 2'b00, 3'd5, 1'b0, 0, 1'b0);
        bus_cycle(32'hF9000000, 32'h3, 1'b1, 2'b00, 3'b111, 1'b0, 0, 1'b0);
        bus_cycle(32'hF9000000, 32'h4, 1'b0, 2'b00, 3'd5, 1'b1, 0, 1'b0);
        bus_cycle(32'hF9000020, 32'h5, 1'b1, 2'b00, 3'd5, 1'b0, 0, 1'b1);
        // Reset pulsed while the backend is being held off.
        never_ack = 1'b1;
        @(negedge cpuclk);
        a = 32'hF9000040; d_in = 32'hDEADBEEF; rwn = 1'b0; siz = 2'b00; fc = 3'd5; asn = 1'b0; dsn = 1'b0;
        repeat (2) @(negedge cpuclk);
        check("pre_reset_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1 check_reset_vals("mid_reset");
        asn = 1'b1; dsn = 1'b1;
        @(negedge cpuclk);
        reset = 1'b0;
        @(negedge cpuclk);
        bus_cycle(32'hF9000044, 32'hCAFEF00D, 1'b0, 2'b00, 3'd5, 1'b0, 0, 1'b0);
        // CPU abort while in the request state.
        never_ack = 1'b1;
        @(negedge cpuclk);
        a = 32'hF9000048; rwn = 1'b1; siz = 2'b00; asn = 1'b0;
        repeat (2) @(negedge cpuclk);
        check("abort_req", {31'd0, mem_req}, 32'd1);
        asn = 1'b1;
        repeat (4) begin
            @(negedge cpuclk);
            check("abort_quiet", {29'd0, mem_req, stermn, berrn}, 32'b011);
        end
        for (int i = 0; i < 40; i++) begin
            ra = {8'hF9, 16'($urandom), 8'($urandom)};
            rf = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) ra[31:24] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) rf = 3'b111;
            bus_cycle(ra, $urandom, 1'($urandom), 2'($urandom), rf, 1'b0, $urandom_range(0, 3), 1'b0);
        end
        for (int i = 0; i < 64; i += 4)
            bus_cycle({8'hF9, 16'h0, 8'(i)}, 32'h0, 1'b1, 2'b00, 3'd5, 1'b0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc68030_pds_slave.md
Name: mc68030_pds_slave

Overview:
- Synchronous-termination bus responder for the 68030 processor direct slot (PDS). It is the target-side counterpart of the CPU bus master.
- Decodes the card's address window (A[31:24] = 0xF0 | CARD_ID, e.g. 0xF9xxxxxx for slot 9). Converts each CPU cycle into a single-beat request on a simple internal memory port.
- Terminates the cycle with a one-clock STERM#, or with BERR# on backend timeout.
- Sits between the level-shifted PDS pins and the card's BRAM/register fabric, clocked by the CPU clock.

Parameters:
- CARD_ID, 4'h9, slot nibble matched against A[27:24]; A[31:28] must equal 4'hF.
- TIMEOUT_CYCLES, 64, cpuclk cycles after mem_req rises before BERR# is raised; range 2..255.

Ports:
- cpuclk  in  1  CPU bus clock; all inputs are sampled on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a  in  32  address bus.
- d_in  in  32  data bus input.
- d_out  out  32  read data driven to the bus.
- d_oe  out  1  data bus output enable.
- rwn  in  1  1 = read, 0 = write.
- asn  in  1  address strobe, active low.
- dsn  in  1  data strobe, active low.
- siz  in  2  transfer size: 00 = long, 01 = byte, 10 = word, 11 = 3-byte.
- fc  in  3  function code.
- stermn  out  1  synchronous termination, active low.
- berrn  out  1  bus error, active low.
- mem_req  out  1  backend request.
- mem_we  out  1  backend write.
- mem_addr  out  22  longword address, equal to A[23:2].
- mem_be  out  4  byte enables; be[3] selects D[31:24].
- mem_wdata  out  32  write data.
- mem_ack  in  1  backend done; may be high in the same cycle as mem_req.
- mem_rdata  in  32  read data, valid when mem_ack is high.

Behaviour:
- Reset values (asynchronous):
  - stermn = 1, berrn = 1, d_oe = 0, d_out = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0.
  - State = IDLE.
- Reset asserted mid-cycle: all outputs return to reset values immediately. No termination is issued for that cycle.
- Cycle qualification: a cycle is accepted only when all of the following are sampled true:
  - asn = 0;
  - A[31:28] = F and A[27:24] = CARD_ID;
  - fc != 3'b111 (CPU-space cycles are ignored, never terminated);
  - for writes, dsn = 0 as well.
- Unmatched cycles: the block never drives stermn, berrn or d_oe.
- State IDLE: when a qualified cycle is sampled, go to REQ.
  - Register mem_req = 1, mem_we = ~rwn, mem_addr = A[23:2], mem_be from the table below, mem_wdata = d_in.
- State REQ:
  - Hold all mem_* outputs until mem_ack is sampled high.
  - On ack: mem_req = 0, stermn = 0, go to TERM. For a read, also d_out = mem_rdata and d_oe = 1.
  - A combinational ack gives stermn low on the second edge after asn is sampled low.
  - Timeout counter starts at 0 when entering REQ. If it reaches TIMEOUT_CYCLES without ack: mem_req = 0, berrn = 0, go to WAIT_AS.
  - If asn is sampled high while in REQ (CPU abort): drop mem_req, no termination, go to IDLE.
- State TERM: stermn is low for exactly one cycle, then driven back to 1. Go to WAIT_AS.
- State WAIT_AS:
  - Hold d_oe (reads) and berrn (error case) until asn is sampled high.
  - Then d_oe = 0, berrn = 1, go to IDLE.
  - A new cycle is never accepted in the same edge that sees asn high.
- Byte enables, listed per siz as A[1:0] = 00 / 01 / 10 / 11:
  - long (00): 1111 / 0111 / 0011 / 0001
  - byte (01): 1000 / 0100 / 0010 / 0001
  - word (10): 1100 / 0110 / 0011 / 0001
  - 3-byte (11): 1110 / 0111 / 0011 / 0001
- Reads always return the full 32-bit longword; mem_be is still driven for reads.
- Address and data are latched once, at acceptance; later bus changes are ignored.

Test Plan:
- Long write: A = F9000000, D = 87654321, siz = 00, always-ack backend -> mem_we = 1, mem_be = 1111, mem_addr = 0, mem_wdata = 87654321. stermn is low for exactly one cycle, two edges after asn falls.
- Long read back: same address, backend returns 87654321 -> d_oe and d_out = 87654321 from the stermn-low cycle until asn is sampled high; then d_oe = 0.
- Sizing, with 2-cycle ack latency:
  - Byte write at F9000013 -> mem_be = 0001, mem_addr = 4.
  - Word write at F9000001 -> mem_be = 0110.
  - stermn is asserted one cycle after ack is sampled.
- Decode rejects, each of A = FA000000, A = E9000000, or fc = 111 -> mem_req, stermn, berrn and d_oe stay inactive for 10 cycles.
- Timeout: backend never acks, TIMEOUT_CYCLES = 8 -> berrn = 0 eight cycles after mem_req rises, mem_req drops, berrn stays low until asn rises, then returns to IDLE.
- Reset and abort:
  - reset pulsed during REQ -> all outputs at reset values immediately; the next long write completes normally.
  - asn raised during REQ -> no termination, back to IDLE.
